// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII PHY loopback emulator.
package rmii_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StDiscard,
    StGap,
    StReplay
  } state_e;

  localparam int unsigned DibitsPerByte = 4;
  localparam logic [15:0] CntSat        = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CntSat) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rmii_phy_loopback_if.sv
// RMII pin bundle between the FPGA MAC (master) and the PHY side (slave).
interface rmii_phy_loopback_if;

    logic       rmii_tx_en;
    logic [1:0] rmii_txd;
    logic       rmii_crs_dv;
    logic [1:0] rmii_rxd;
    logic       rmii_rx_er;

    modport master (
        output rmii_tx_en, rmii_txd,
        input  rmii_crs_dv, rmii_rxd, rmii_rx_er
    );

    modport slave (
        input  rmii_tx_en, rmii_txd,
        output rmii_crs_dv, rmii_rxd, rmii_rx_er
    );

endinterface

// File: rtl/rmii_frame_ram.sv
// Simple dual-port DEPTHx8 frame buffer with a registered read port (BRAM style).
module rmii_frame_ram #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic                     clock50,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock50) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/rmii_phy_loopback.sv
// PHY-side RMII loopback: captures one MAC frame, waits a gap, replays it verbatim.
module rmii_phy_loopback
    import rmii_pkg::*;
#(
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned GAP_CYCLES = 24
) (
    input  logic                clock50,
    input  logic                resetn,
    input  logic                enable,
    rmii_phy_loopback_if.slave  rmii,
    output logic                busy,
    output logic [15:0]         frames_looped,
    output logic [15:0]         frames_dropped
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned GapW    = $clog2(GAP_CYCLES + 1);
    localparam logic [AW:0] FullLen = (AW + 1)'(DEPTH);
    localparam logic [1:0]  LastDib = 2'(DibitsPerByte - 1);

    state_e          state_q, state_d;
    logic            tx_en_d_q;
    logic [7:0]      cap_sh_q;
    logic [1:0]      cap_dcnt_q;
    logic [AW:0]     wr_len_q;
    logic            ovf_q;
    logic [GapW-1:0] gap_q;
    logic [AW+2:0]   rem_q;
    logic [AW-1:0]   rd_addr_q;
    logic [5:0]      rep_sh_q;
    logic            crs_dv_q;
    logic [1:0]      rxd_q;
    logic            busy_q;
    logic [15:0]     looped_q, dropped_q;

    logic cap_start, cap_shift, ram_we, ovf_set, drop_inc, gap_load, rd_start, loop_done;
    logic ram_re;
    logic [AW-1:0] ram_raddr;
    logic [7:0] ram_rdata;

    always_comb begin
        state_d   = state_q;
        cap_start = 1'b0;
        cap_shift = 1'b0;
        ram_we    = 1'b0;
        ovf_set   = 1'b0;
        drop_inc  = 1'b0;
        gap_load  = 1'b0;
        rd_start  = 1'b0;
        loop_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Disabled frames are ignored outright; a frame already under way is dropped.
                if (rmii.rmii_tx_en && enable) begin
                    if (tx_en_d_q) begin
                        state_d = StDiscard;
                    end else begin
                        state_d   = StCapture;
                        cap_start = 1'b1;
                    end
                end
            end
            StCapture: begin
                if (rmii.rmii_tx_en) begin
                    cap_shift = 1'b1;
                    if (cap_dcnt_q == LastDib) begin
                        if (wr_len_q == FullLen) ovf_set = 1'b1;
                        else                     ram_we  = 1'b1;
                    end
                end else if (cap_dcnt_q != 2'd0 || ovf_q || wr_len_q == '0) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end else begin
                    gap_load = 1'b1;
                    state_d  = StGap;
                end
            end
            StDiscard: begin
                if (!rmii.rmii_tx_en) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    rd_start = 1'b1;
                    state_d  = StReplay;
                end
            end
            StReplay: begin
                if (rem_q == '0) begin
                    loop_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Fetch the next byte on the same edge the current one is consumed, so no bubbles.
    assign ram_re    = rd_start | (state_q == StReplay && rem_q != '0 && rem_q[1:0] == 2'd0);
    assign ram_raddr = rd_start ? '0 : rd_addr_q;

    always_ff @(posedge clock50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            tx_en_d_q  <= 1'b0;
            cap_sh_q   <= '0;
            cap_dcnt_q <= '0;
            wr_len_q   <= '0;
            ovf_q      <= 1'b0;
            gap_q      <= '0;
            rem_q      <= '0;
            rd_addr_q  <= '0;
            rep_sh_q   <= '0;
            crs_dv_q   <= 1'b0;
            rxd_q      <= '0;
            busy_q     <= 1'b0;
            looped_q   <= '0;
            dropped_q  <= '0;
        end else begin
            state_q   <= state_d;
            tx_en_d_q <= rmii.rmii_tx_en;
            busy_q    <= (state_d != StIdle);
            if (cap_start) begin
                cap_sh_q   <= {rmii.rmii_txd, cap_sh_q[7:2]};
                cap_dcnt_q <= 2'd1;
                wr_len_q   <= '0;
                ovf_q      <= 1'b0;
            end
            if (cap_shift) begin
                cap_sh_q   <= {rmii.rmii_txd, cap_sh_q[7:2]};
                cap_dcnt_q <= cap_dcnt_q + 2'd1;
            end
            if (ram_we)  wr_len_q <= wr_len_q + 1'b1;
            if (ovf_set) ovf_q <= 1'b1;
            if (gap_load) begin
                gap_q <= GapW'(GAP_CYCLES);
            end else if (state_q == StGap && gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
            if (rd_start) begin
                rd_addr_q <= (AW)'(1);
                rem_q     <= {wr_len_q, 2'b00};
            end
            if (state_q == StReplay && rem_q != '0) begin
                rem_q    <= rem_q - 1'b1;
                crs_dv_q <= 1'b1;
                if (rem_q[1:0] == 2'd0) begin
                    rxd_q     <= ram_rdata[1:0];
                    rep_sh_q  <= ram_rdata[7:2];
                    rd_addr_q <= rd_addr_q + 1'b1;
                end else begin
                    rxd_q    <= rep_sh_q[1:0];
                    rep_sh_q <= {2'b00, rep_sh_q[5:2]};
                end
            end
            if (loop_done) begin
                crs_dv_q <= 1'b0;
                rxd_q    <= '0;
                looped_q <= sat_inc(looped_q);
            end
            if (drop_inc) dropped_q <= sat_inc(dropped_q);
        end
    end

    rmii_frame_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clock50 (clock50),
        .we      (ram_we),
        .waddr   (wr_len_q[AW-1:0]),
        .wdata   ({rmii.rmii_txd, cap_sh_q[7:2]}),
        .re      (ram_re),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata)
    );

    assign rmii.rmii_crs_dv = crs_dv_q;
    assign rmii.rmii_rxd    = rxd_q;
    assign rmii.rmii_rx_er  = 1'b0;
    assign busy             = busy_q;
    assign frames_looped    = looped_q;
    assign frames_dropped   = dropped_q;

endmodule

// File: tb/tb_rmii_phy_loopback.sv
// Scoreboard bench: sent frames queue expected dibits; a monitor checks every replayed dibit.
module tb_rmii_phy_loopback;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned GAP   = 24;

    logic        clock50 = 1'b0;
    logic        resetn  = 1'b0;
    logic        enable  = 1'b1;
    logic        busy;
    logic [15:0] frames_looped, frames_dropped;

    rmii_phy_loopback_if rmii ();

    rmii_phy_loopback #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock50        (clock50),
        .resetn         (resetn),
        .enable         (enable),
        .rmii           (rmii),
        .busy           (busy),
        .frames_looped  (frames_looped),
        .frames_dropped (frames_dropped)
    );

    always #10 clock50 = ~clock50;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;
    always @(posedge clock50) edge_cnt <= edge_cnt + 1;

    logic [1:0] exp_q[$];
    int         start_q[$];
    int         len_q[$];
    logic [1:0] dq[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: replay start edge, every dibit, and replay length.
    bit in_run = 1'b0;
    int run_len = 0;
    initial begin
        forever begin
            @(negedge clock50);
            if (!resetn) begin
                in_run  = 1'b0;
                run_len = 0;
            end else if (rmii.rmii_crs_dv) begin
                if (!in_run) begin
                    in_run  = 1'b1;
                    run_len = 0;
                    if (start_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_replay: got start at edge %0d expected none",
                                 edge_cnt);
                    end else begin
                        check("replay_start_edge", edge_cnt, start_q.pop_front());
                    end
                end
                run_len++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_dibit: got %0d expected none", rmii.rmii_rxd);
                end else begin
                    check("rxd", int'(rmii.rmii_rxd), int'(exp_q.pop_front()));
                end
                check("rx_er", int'(rmii.rmii_rx_er), 0);
            end else if (in_run) begin
                in_run = 1'b0;
                if (len_q.size() != 0) check("replay_len", run_len, len_q.pop_front());
                check("rxd_idle", int'(rmii.rmii_rxd), 0);
            end
        end
    end

    task automatic build_frame(input int nbytes, input int extra_dibits);
        logic [7:0] b;
        dq.delete();
        for (int i = 0; i < nbytes; i++) begin
            if (i < 7)       b = 8'h55;
            else if (i == 7) b = 8'hD5;
            else             b = 8'(i * 7 + 3);
            for (int k = 0; k < 4; k++) dq.push_back(b[2*k +: 2]);
        end
        for (int k = 0; k < extra_dibits; k++) dq.push_back(2'(k + 1));
    endtask

    task automatic send(input bit expect_loop);
        int t_edge;
        for (int i = 0; i < dq.size(); i++) begin
            @(negedge clock50);
            rmii.rmii_tx_en = 1'b1;
            rmii.rmii_txd   = dq[i];
        end
        @(negedge clock50);
        rmii.rmii_tx_en = 1'b0;
        rmii.rmii_txd   = 2'b00;
        t_edge = edge_cnt + 1;
        if (expect_loop) begin
            foreach (dq[i]) exp_q.push_back(dq[i]);
            start_q.push_back(t_edge + GAP + 2);
            len_q.push_back(dq.size());
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 4 * DEPTH + GAP + 100; i++) begin
            @(negedge clock50);
            if (!busy && !rmii.rmii_crs_dv) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic wait_crs(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < GAP + 20; i++) begin
            @(negedge clock50);
            if (rmii.rmii_crs_dv) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_crs_timeout"}, 1, 0);
    endtask

    task automatic check_counts(input string name, input int looped, input int dropped);
        check({name, "_looped"}, int'(frames_looped), looped);
        check({name, "_dropped"}, int'(frames_dropped), dropped);
    endtask

    initial begin
        rmii.rmii_tx_en = 1'b0;
        rmii.rmii_txd   = 2'b00;
        #15;
        check("rst_crs_dv", int'(rmii.rmii_crs_dv), 0);
        check("rst_rxd", int'(rmii.rmii_rxd), 0);
        check("rst_busy", int'(busy), 0);
        check_counts("rst", 0, 0);
        @(posedge clock50);
        #5 resetn = 1'b1;

        // Standard 72-byte frame
        build_frame(72, 0);
        send(1'b1);
        wait_idle("f72");
        check_counts("f72", 1, 0);

        // 290 dibits: partial byte, dropped immediately
        build_frame(72, 2);
        send(1'b0);
        @(negedge clock50);
        check("partial_busy", int'(busy), 0);
        repeat (GAP + 10) @(negedge clock50);
        check_counts("partial", 1, 1);

        // Exactly DEPTH bytes fits
        build_frame(DEPTH, 0);
        send(1'b1);
        wait_idle("full");
        check_counts("full", 2, 1);

        // DEPTH+1 bytes overflows, then a normal frame still loops
        build_frame(DEPTH + 1, 0);
        send(1'b0);
        repeat (GAP + 10) @(negedge clock50);
        check_counts("oversize", 2, 2);
        build_frame(72, 0);
        send(1'b1);
        wait_idle("after_ovf");
        check_counts("after_ovf", 3, 2);

        // Second frame starts during replay of the first
        build_frame(72, 0);
        send(1'b1);
        wait_crs("overlap");
        repeat (10) @(negedge clock50);
        send(1'b0);
        wait_idle("overlap");
        check_counts("overlap", 4, 3);
        build_frame(40, 0);
        send(1'b1);
        wait_idle("third");
        check_counts("third", 5, 3);

        // Reset mid-replay
        build_frame(72, 0);
        send(1'b1);
        wait_crs("rst_mid");
        repeat (20) @(negedge clock50);
        @(posedge clock50);
        #5 resetn = 1'b0;
        #1;
        check("midrst_crs_dv", int'(rmii.rmii_crs_dv), 0);
        check("midrst_rxd", int'(rmii.rmii_rxd), 0);
        check("midrst_busy", int'(busy), 0);
        check_counts("midrst", 0, 0);
        exp_q.delete();
        start_q.delete();
        len_q.delete();
        repeat (3) @(posedge clock50);
        #5 resetn = 1'b1;

        // Disabled: frame ignored and not counted
        enable = 1'b0;
        build_frame(72, 0);
        send(1'b0);
        repeat (GAP + 20) @(negedge clock50);
        check_counts("disabled", 0, 0);
        enable = 1'b1;

        build_frame(72, 0);
        send(1'b1);
        wait_idle("post_rst");
        check_counts("post_rst", 1, 0);

        repeat (5) @(negedge clock50);
        check("exp_q_drained", exp_q.size(), 0);
        check("start_q_drained", start_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
